// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device command transmitter. Runs the inhibit,
//                request-to-send, device-clocked shift and ACK phases and
//                drives both open-collector lines through *_oe outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int RTS_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       timeout_err
);

    // One shared counter serves inhibit, RTS and timeout timing.
    localparam int c_MAX_A   = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int c_CNT_MAX = (c_MAX_A > TIMEOUT_CYCLES) ? c_MAX_A : TIMEOUT_CYCLES;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CW-1:0] c_INH_LAST = c_CW'(INHIBIT_CYCLES - 1);
    localparam logic [c_CW-1:0] c_RTS_LAST = c_CW'(RTS_CYCLES - 1);
    localparam logic [c_CW-1:0] c_TO_LAST  = c_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_RTS       = 3'd2;
    localparam logic [2:0] S_SHIFT     = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic [c_CW-1:0] r_cnt;
    logic [8:0]      r_shift;      // {parity, data}, shifted out LSB first
    logic [3:0]      r_bit_cnt;
    logic            r_dat_drive;  // DAT pull-down request while shifting
    logic            r_ack_ok;
    logic            r_done;
    logic            r_timeout_err;
    logic            r_clk_meta, r_clk_sync, r_clk_prev;
    logic            r_dat_meta, r_dat_sync;
    logic            w_clk_fall;
    logic            w_timeout;

    assign w_clk_fall = r_clk_prev & ~r_clk_sync;
    // A falling edge in the last counted cycle restarts the window instead.
    assign w_timeout  = (r_cnt == c_TO_LAST) && !w_clk_fall;

    // Two-flop synchronisers; idle-high reset values avoid a false edge.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk_in;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2_dat_in;
            r_dat_sync <= r_dat_meta;
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (cmd_valid) w_state_next = S_INHIBIT;
            S_INHIBIT:   if (r_cnt == c_INH_LAST) w_state_next = S_RTS;
            S_RTS:       if (r_cnt == c_RTS_LAST) w_state_next = S_SHIFT;
            S_SHIFT: begin
                if (w_timeout)                              w_state_next = S_IDLE;
                else if (w_clk_fall && r_bit_cnt == 4'd9)   w_state_next = S_ACK;
            end
            S_ACK: begin
                if (w_timeout)       w_state_next = S_IDLE;
                else if (w_clk_fall) w_state_next = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (w_timeout)                    w_state_next = S_IDLE;
                else if (r_clk_sync && r_dat_sync) w_state_next = S_IDLE;
            end
            default:     w_state_next = S_IDLE;
        endcase
    end

    // Datapath: counters, frame shifter, DAT drive and status pulses.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_cnt         <= '0;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_dat_drive   <= 1'b0;
            r_ack_ok      <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_shift   <= {~^cmd_data, cmd_data};
                        r_bit_cnt <= '0;
                        r_cnt     <= '0;
                        r_ack_ok  <= 1'b0;
                    end
                end
                S_INHIBIT: r_cnt <= (r_cnt == c_INH_LAST) ? '0 : r_cnt + c_CNT_ONE;
                S_RTS: begin
                    if (r_cnt == c_RTS_LAST) begin
                        r_cnt       <= '0;
                        r_dat_drive <= 1'b1;   // start bit keeps DAT low
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_SHIFT: begin
                    if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                        r_dat_drive   <= 1'b0;
                    end else if (w_clk_fall) begin
                        r_cnt       <= '0;
                        r_dat_drive <= (r_bit_cnt == 4'd9) ? 1'b0 : ~r_shift[0];
                        r_shift     <= {1'b0, r_shift[8:1]};
                        r_bit_cnt   <= r_bit_cnt + 4'd1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_ACK: begin
                    if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                    end else if (w_clk_fall) begin
                        r_ack_ok <= ~r_dat_sync;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_timeout)                     r_timeout_err <= 1'b1;
                    else if (r_clk_sync && r_dat_sync) r_done        <= 1'b1;
                    else                               r_cnt         <= r_cnt + c_CNT_ONE;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Outputs decoded from state so reset releases the lines immediately.
    always_comb begin
        cmd_ready  = (r_state == S_IDLE);
        busy       = (r_state != S_IDLE);
        ps2_clk_oe = (r_state == S_INHIBIT) || (r_state == S_RTS);
        ps2_dat_oe = (r_state == S_RTS) || ((r_state == S_SHIFT) && r_dat_drive);
    end

    assign done        = r_done;
    assign ack_ok      = r_ack_ok;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Self-checking bench for ps2_host_tx with a PS/2 device
//                model, expected-result queue and decoupled monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int c_INH = 60;
    localparam int c_RTS = 5;
    localparam int c_TO  = 400;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready, ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       busy, done, ack_ok, timeout_err;
    logic       dev_clk_low, dev_dat_low;
    logic [9:0] dev_frame;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit         is_timeout;
        bit         ack;
        logic [9:0] frame;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    // Wired-AND open-collector bus.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    always #10 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(c_INH),
        .RTS_CYCLES    (c_RTS),
        .TIMEOUT_CYCLES(c_TO)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .ack_ok     (ack_ok),
        .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference frame: 8 data bits LSB first, odd parity, stop bit 1.
    function automatic exp_t model(input logic [7:0] d, input bit ack, input bit to);
        exp_t e;
        int   ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        e.is_timeout = to;
        e.ack        = ack;
        e.data       = d;
        e.frame      = {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
        return e;
    endfunction

    // Issue one command; push expectation only when a result is due.
    task automatic send(input logic [7:0] d, input bit ack, input bit to, input bit expect_result);
        @(negedge clk);
        cmd_data  = d;
        cmd_valid = 1'b1;
        if (expect_result) sb.push_back(model(d, ack, to));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("accept_busy", busy, 1);
        check("ack_ok_cleared", ack_ok, 0);
    endtask

    // Device model: waits for CLK release, then clocks the frame in.
    task automatic device(input int half, input bit ack, input int abort_at, input bit no_clock);
        int low = 0;
        while (ps2_clk_in === 1'b0 && low < 5000) begin
            cyc(1);
            low++;
        end
        check("inhibit_len_ok", (low >= c_INH + c_RTS && low < 5000) ? 1 : 0, 1);
        check("start_bit", ps2_dat_in, 0);
        if (no_clock) return;
        for (int k = 0; k < 10; k++) begin
            cyc(half);
            dev_clk_low = 1'b1;
            if (k == abort_at) return;
            cyc(half);
            dev_clk_low = 1'b0;
            cyc(2);
            dev_frame[k] = ps2_dat_in;
        end
        cyc(half / 2);
        if (ack) dev_dat_low = 1'b1;
        cyc(half / 2);
        dev_clk_low = 1'b1;
        cyc(half);
        dev_clk_low = 1'b0;
        cyc(half / 2);
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 20000) begin
            cyc(1);
            n++;
        end
        check("result_arrived", sb.size(), 0);
        cyc(3);
    endtask

    // Monitor: pops the expected result whenever the DUT reports one.
    always @(negedge clk) begin
        if (resetn === 1'b1 && (done === 1'b1 || timeout_err === 1'b1)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: done=%0b timeout_err=%0b with nothing pending", done, timeout_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_kind_timeout", timeout_err, e.is_timeout);
                check("result_kind_done", done, !e.is_timeout);
                if (e.is_timeout) begin
                    check("to_lines_released", {ps2_clk_oe, ps2_dat_oe}, 0);
                    check("to_cmd_ready", cmd_ready, 1);
                end else begin
                    check("ack_ok", ack_ok, e.ack);
                    check("frame_bits", dev_frame, e.frame);
                end
            end
        end
    end

    // Overall watchdog.
    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetn      = 1'b0;
        cmd_valid   = 1'b0;
        cmd_data    = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        dev_frame   = '0;
        cyc(3);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_outputs", {busy, done, ack_ok, timeout_err, ps2_clk_oe, ps2_dat_oe}, 0);
        @(negedge clk);
        resetn = 1'b1;
        cyc(3);

        // 0xED with ACK, plus an ignored 0x00 request while busy.
        send(8'hED, 1, 0, 1);
        fork
            device(25, 1, -1, 0);
            begin
                @(negedge clk);
                repeat (9) @(negedge clk);
                cmd_data  = 8'h00;
                cmd_valid = 1'b1;
                #1;
                check("busy_not_ready", cmd_ready, 0);
                @(negedge clk);
                cmd_valid = 1'b0;
            end
        join
        wait_drain();
        check("no_requeue", busy, 0);
        check("ack_ok_held", ack_ok, 1);

        // 0xF4 with ACK.
        send(8'hF4, 1, 0, 1);
        device(30, 1, -1, 0);
        wait_drain();

        // NACK: DAT left high at the ACK edge.
        send(8'hED, 0, 0, 1);
        device(20, 0, -1, 0);
        wait_drain();

        // No device clock after RTS -> timeout.
        send(8'h55, 0, 1, 1);
        device(20, 0, -1, 1);
        n = 0;
        while (timeout_err !== 1'b1 && n < 3 * c_TO) begin
            cyc(1);
            n++;
        end
        check("timeout_latency", (n >= c_TO - 2 && n <= c_TO + 2) ? 1 : 0, 1);
        wait_drain();

        // Asynchronous reset during bit 4 of 0xE0 (DAT driven low then).
        send(8'hE0, 1, 0, 0);
        device(20, 1, 4, 0);
        cyc(5);
        check("pre_reset_dat_driven", ps2_dat_oe, 1);
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst_lines", {ps2_clk_oe, ps2_dat_oe}, 0);
        check("async_rst_ready", {cmd_ready, busy, done}, 3'b100);
        dev_clk_low = 1'b0;
        cyc(3);
        @(negedge clk);
        resetn = 1'b1;
        cyc(3);
        send(8'hFF, 1, 0, 1);
        device(25, 1, -1, 0);
        wait_drain();

        // Randomised commands, ACK/NACK and device clock rates.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            bit         a;
            int         h;
            d = 8'($urandom);
            a = ($urandom_range(0, 3) != 0);
            h = $urandom_range(10, 50);
            send(d, a, 0, 1);
            device(h, a, -1, 0);
            wait_drain();
        end

        check("queue_empty_end", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
